// File: rtl/fetch_pc_unit_pkg.sv
// Shared widths, defaults and fetch-state encoding for the instruction-fetch front end.
package fetch_pc_unit_pkg;

  localparam int unsigned ADDR       = 32;
  localparam int unsigned W_INST     = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  // StDrain means stale responses from before a redirect are still in flight.
  typedef enum logic {
    StRun   = 1'b0,
    StDrain = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; flush wins over push and pop in the same cycle.
// Depth must be a power of two >= 2. Storage is reset so the head reads zero after reset.
module fetch_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wptr_q, wptr_d;
  logic [PtrW:0]    rptr_q, rptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign data_o  = mem_q[rptr_q[PtrW-1:0]];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Pointer next-state: flush empties, otherwise advance on push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wptr_q[PtrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited in-order fetches,
// buffers responses with their PCs for decode, and redirects/flushes on a taken branch.
// Optional build macro FETCH_PERF_EN adds saturating pop and redirect counters.
module fetch_pc_unit #(
  parameter int unsigned     ADDR      = fetch_pc_unit_pkg::ADDR,
  parameter int unsigned     W_INST    = fetch_pc_unit_pkg::W_INST,
  parameter logic [ADDR-1:0] RESET_PC  = ADDR'(fetch_pc_unit_pkg::RESET_PC),
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_i,
  input  logic [ADDR-1:0]   branch_addr_i,
  output logic              imem_req_o,
  output logic [ADDR-1:0]   imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [W_INST-1:0] imem_rdata_i,
  output logic              v_o,
  output logic [ADDR-1:0]   pc_o,
  output logic [W_INST-1:0] inst_o,
  input  logic              ready_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_o,
  output logic [31:0]       perf_redirect_o
`endif
);

  import fetch_pc_unit_pkg::*;

  localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned BufW = ADDR + W_INST;

  fetch_state_e    state_q, state_d;
  logic [ADDR-1:0] pc_q, pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [CntW:0]   inflight;

  logic            grant, keep_rsp, pop;
  logic            buf_full, buf_empty;
  logic [CntW-1:0] buf_count;
  logic [BufW-1:0] buf_rdata;
  logic            req_full, req_empty;
  logic [CntW-1:0] req_count;
  logic [ADDR-1:0] req_pc;
  logic            unused_branch_lsb;

  // Target is word aligned; the two low bits of the branch address are ignored.
  assign unused_branch_lsb = ^branch_addr_i[1:0];

  // Credit: never have more fetches in flight or buffered than the buffer can hold.
  assign inflight    = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign imem_req_o  = (inflight < (CntW+1)'(BUF_DEPTH)) & ~branch_i & ~rst;
  assign imem_addr_o = pc_q;
  assign grant       = imem_req_o & imem_gnt_i;

  // Responses arriving while draining belong to the pre-redirect path.
  assign keep_rsp = imem_rvalid_i & (state_q == StRun) & ~branch_i;
  assign pop      = v_o & ready_i;

  assign v_o            = ~buf_empty;
  assign {pc_o, inst_o} = buf_rdata;

  fetch_fifo #(
    .Width (BufW),
    .Depth (BUF_DEPTH)
  ) u_inst_buf (
    .clk     (clk),
    .rst     (rst),
    .flush_i (branch_i),
    .push_i  (keep_rsp),
    .data_i  ({req_pc, imem_rdata_i}),
    .pop_i   (pop),
    .data_o  (buf_rdata),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  fetch_fifo #(
    .Width (ADDR),
    .Depth (BUF_DEPTH)
  ) u_req_pc (
    .clk     (clk),
    .rst     (rst),
    .flush_i (branch_i),
    .push_i  (grant),
    .data_i  (pc_q),
    .pop_i   (keep_rsp),
    .data_o  (req_pc),
    .full_o  (req_full),
    .empty_o (req_empty),
    .count_o (req_count)
  );

  // Next PC, in-flight/drop accounting and RUN/DRAIN state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    case ({grant, imem_rvalid_i})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: ;
    endcase

    if (branch_i) begin
      // Everything still in flight after this cycle is wrong-path.
      pc_d   = {branch_addr_i[ADDR-1:2], 2'b00};
      drop_d = outstanding_q - CntW'(imem_rvalid_i);
    end else begin
      if (grant) pc_d = pc_q + ADDR'(INST_BYTES);
      if (imem_rvalid_i && (state_q == StDrain)) drop_d = drop_q - 1'b1;
    end

    state_d = (drop_d != '0) ? StDrain : StRun;
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_redirect_q;

  // Saturating event counters; a pop flushed by a redirect is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q    <= '0;
      perf_redirect_q <= '0;
    end else begin
      if (pop && !branch_i && (perf_fetch_q != '1)) perf_fetch_q <= perf_fetch_q + 1'b1;
      if (branch_i && (perf_redirect_q != '1)) perf_redirect_q <= perf_redirect_q + 1'b1;
    end
  end

  assign perf_fetch_o    = perf_fetch_q;
  assign perf_redirect_o = perf_redirect_q;
`endif

  // Credit accounting must make these impossible.
  buf_no_overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(keep_rsp && buf_full));
  req_no_overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(grant && req_full));
  rsp_has_pc_a: assert property (@(posedge clk) disable iff (rst)
    !(keep_rsp && req_empty));
  req_le_outstanding_a: assert property (@(posedge clk) disable iff (rst)
    req_count <= outstanding_q);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based model of the fetch front end.
module tb_fetch_pc_unit;

  localparam int unsigned Depth = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        v_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        ready_i;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_o;
  logic [31:0] perf_redirect_o;
`endif

  fetch_pc_unit #(
    .ADDR      (32),
    .W_INST    (32),
    .RESET_PC  (32'h0),
    .BUF_DEPTH (Depth)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .v_o           (v_o),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .ready_i       (ready_i)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_o    (perf_fetch_o),
    .perf_redirect_o (perf_redirect_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; } out_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] addr; int due; } rsp_t;

  // Model: fetches in flight (oldest first), buffered instructions, and the PC.
  out_t        m_out[$];
  ent_t        m_buf[$];
  logic [31:0] m_pc;
  int          m_pops;
  int          m_redirs;

  // Memory responder: granted addresses with the cycle their response may return.
  rsp_t        mem_q[$];

  logic [31:0] pop_log[$];
  logic [31:0] grant_log[$];
  bit          cap_done;
  logic [31:0] cap_pc, cap_inst;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int max_lat  = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    m_out.delete();
    m_buf.delete();
    mem_q.delete();
    pop_log.delete();
    grant_log.delete();
    m_pc     = 32'h0;
    m_pops   = 0;
    m_redirs = 0;
    cap_done = 1'b0;
  endtask

  // Asynchronous assert mid-cycle, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    branch_i      = 1'b0;
    branch_addr_i = 32'h0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    ready_i       = 1'b0;
    rst           = 1'b1;
    #1;
    chk("rst_req", imem_req_o, 1'b0);
    chk("rst_v", v_o, 1'b0);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_inst_o", inst_o, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetch", perf_fetch_o, 32'h0);
    chk("rst_perf_redirect", perf_redirect_o, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input bit br, input logic [31:0] ba, input bit gnt, input bit rv_en,
                      input bit rdy);
    bit   exp_req, exp_v, rv;
    rsp_t r;
    out_t o;
    @(negedge clk);
    branch_i      = br;
    branch_addr_i = ba;
    imem_gnt_i    = gnt;
    ready_i       = rdy;
    rv            = 1'b0;
    if (rv_en && (mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
      r            = mem_q.pop_front();
      rv           = 1'b1;
      imem_rdata_i = mem_word(r.addr);
    end else begin
      imem_rdata_i = $urandom;
    end
    imem_rvalid_i = rv;
    #1;

    exp_req = ((m_out.size() + m_buf.size()) < Depth) && !br;
    exp_v   = m_buf.size() > 0;
    chk("imem_req", imem_req_o, exp_req);
    chk("imem_addr", imem_addr_o, m_pc);
    chk("v", v_o, exp_v);
    if (exp_v) begin
      chk("pc_o", pc_o, m_buf[0].pc);
      chk("inst_o", inst_o, m_buf[0].inst);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_o, m_pops);
    chk("perf_redirect", perf_redirect_o, m_redirs);
`endif

    if (v_o && !cap_done) begin
      cap_done = 1'b1;
      cap_pc   = pc_o;
      cap_inst = inst_o;
    end
    if (v_o && rdy && !br) pop_log.push_back(pc_o);
    if (imem_req_o && gnt) begin
      grant_log.push_back(imem_addr_o);
      mem_q.push_back('{addr: imem_addr_o, due: cyc + int'($urandom_range(max_lat, 1))});
    end

    if (exp_v && rdy && !br) begin
      void'(m_buf.pop_front());
      m_pops++;
    end
    if (rv && (m_out.size() > 0)) begin
      o = m_out.pop_front();
      if (!o.stale && !br) m_buf.push_back('{pc: o.addr, inst: mem_word(o.addr)});
    end
    if (br) begin
      m_buf.delete();
      foreach (m_out[i]) m_out[i].stale = 1'b1;
      m_pc = {ba[31:2], 2'b00};
      m_redirs++;
    end else if (exp_req && gnt) begin
      m_out.push_back('{addr: m_pc, stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    cyc++;
  endtask

  initial begin
    rst           = 1'b1;
    branch_i      = 1'b0;
    branch_addr_i = 32'h0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    ready_i       = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);

    // Streaming with one-cycle memory latency.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      if (i == 0) begin
        chk("a_first_req", imem_req_o, 1'b1);
        chk("a_first_addr", imem_addr_o, 32'h0);
        chk("a_first_v", v_o, 1'b0);
      end
      if (i == 1) chk("a_fill_v1", v_o, 1'b0);
      if (i == 2) chk("a_fill_v2", v_o, 1'b1);
    end
    if (pop_log.size() >= 4) begin
      chk("a_pop0", pop_log[0], 32'h0);
      chk("a_pop1", pop_log[1], 32'h4);
      chk("a_pop2", pop_log[2], 32'h8);
      chk("a_pop3", pop_log[3], 32'hC);
    end else begin
      chk("a_pop_count", pop_log.size(), 4);
    end

    // Backpressure: two grants fill the credit, then fetch stalls.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("b_grants", grant_log.size(), 2);
    chk("b_req_off", imem_req_o, 1'b0);
    pop_log.delete();
    grant_log.delete();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    if ((pop_log.size() >= 2) && (grant_log.size() >= 1)) begin
      chk("b_pop0", pop_log[0], 32'h0);
      chk("b_pop1", pop_log[1], 32'h4);
      chk("b_resume", grant_log[0], 32'h8);
    end else begin
      chk("b_resume_seen", 1'b0, 1'b1);
    end

    // Redirect with two fetches in flight.
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h102, 1'b1, 1'b0, 1'b1);
    chk("c_no_req_on_branch", imem_req_o, 1'b0);
    cap_done = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("c_captured", cap_done, 1'b1);
    chk("c_pc", cap_pc, 32'h100);
    chk("c_inst", cap_inst, 32'h5B5A_F1F0);

    // Branch coinciding with responses, back to back.
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
    step(1'b1, 32'h301, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("d_captured", cap_done, 1'b1);
    chk("d_pc", cap_pc, 32'h300);

    // PC wraps past the top of the address space.
    do_reset();
    step(1'b1, 32'hFFFF_FFFB, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    if (grant_log.size() >= 3) begin
      chk("w_grant0", grant_log[0], 32'hFFFF_FFF8);
      chk("w_grant2", grant_log[2], 32'h0);
    end else begin
      chk("w_grant_count", grant_log.size(), 3);
    end

    // Random traffic with variable latency and a mid-stream reset.
    max_lat = 3;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] ba;
      if (i == 2000) do_reset();
      ba = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
      step($urandom_range(19, 0) == 0, ba, $urandom_range(9, 0) < 7,
           $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end: owns the program counter and issues in-order requests to instruction memory.
- Buffers returned instructions with their PCs and presents them downstream to decode.
- Consumes the execute-stage branch result (taken flag plus target address) to redirect fetch and flush wrong-path work.
- Completes the branch loop: execute resolves, this block redirects.

Parameters:
- ADDR, 32, address/PC width; matches the execute stage's branch target width.
- W_INST, 32, instruction word width.
- RESET_PC, 0, PC loaded on reset.
- BUF_DEPTH, 2, instruction buffer entries; a power of two ≥2; also the credit limit.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- branch_i  in  1  taken-branch strobe from execute; single-cycle.
- branch_addr_i  in  ADDR  branch target; valid when branch_i=1.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  ADDR  fetch address (current PC).
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid; in order, one per grant, latency ≥1 cycle.
- imem_rdata_i  in  W_INST  response instruction.
- v_o  out  1  buffer head valid to decode.
- pc_o  out  ADDR  PC of head instruction.
- inst_o  out  W_INST  head instruction.
- ready_i  in  1  decode accepts head this cycle.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC.
  - Buffer empty; outstanding count and drop count are 0.
  - v_o=0, imem_req_o=0, pc_o/inst_o=0.
  - First request may assert in the first cycle after rst deasserts.
- Credit rule:
  - imem_req_o = (outstanding + buffered < BUF_DEPTH) & ~branch_i.
  - imem_addr_o = pc.
- Grant: on imem_req_o & imem_gnt_i, pc <= pc+4 (mod 2^ADDR, wraps silently) and outstanding increments.
- Response:
  - On imem_rvalid_i, outstanding decrements.
  - If drop count > 0, the response is discarded and drop count decrements.
  - Otherwise {pc of request, imem_rdata_i} is pushed to the buffer tail. A request-PC FIFO of BUF_DEPTH entries tracks issued PCs.
  - A push into a full buffer is impossible by the credit rule; assert this in simulation.
- Output:
  - v_o = buffer non-empty; pc_o/inst_o = head, registered.
  - Pop on v_o & ready_i.
  - Push and pop in the same cycle are both honoured.
  - A response is visible on v_o one cycle after imem_rvalid_i.
- Redirect on branch_i, which has priority over everything:
  - pc <= {branch_addr_i[ADDR-1:2], 2'b00}; low bits are forced to zero.
  - Buffer and request-PC FIFO are cleared.
  - drop count <= outstanding minus (1 if imem_rvalid_i this cycle and drop count was 0), plus any existing drop count net of this cycle's response.
  - No request is issued in the redirect cycle. A pop in that cycle is discarded with the flush.
- Back-to-back branch_i: the last target wins; drop accounting stays exact.
- States: RUN (normal issue) and DRAIN (drop count > 0). Requests to the new PC are allowed in DRAIN, subject to credit; their responses are kept only after drop count reaches 0.
- rst mid-operation clears everything. Stale imem responses after reset are the memory's responsibility; imem must also be reset.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_o (32b, count of buffer pops) and perf_redirect_o (32b, count of branch_i cycles, including back-to-back). Both reset to 0, saturate at all-ones, update the cycle after the event.
- Undefined: ports and counters absent; logic otherwise identical.

Decomposition:
- Shared package/include holds ADDR, W_INST, INST_BYTES=4, RESET_PC default, and the fetch-state encoding (RUN=0, DRAIN=1).
- One natural sub-module: fetch_fifo, a parameterised synchronous FIFO with flush, push, pop, full and empty. It is instanced twice: the instruction buffer {pc,inst} and the request-PC FIFO.

Test Plan:
- Reset: rst high mid-stream, then released → v_o=0, first imem_addr_o=0x0, imem_req_o=1 on the next cycle.
- Streaming: gnt=1, 1-cycle latency, ready_i=1 → pc_o sequence 0x0,0x4,0x8,0xC on consecutive cycles after a 2-cycle fill.
- Backpressure: ready_i=0 → exactly 2 grants, then imem_req_o=0. Raising ready_i → pops 0x0, 0x4 in order, then fetch resumes at 0x8.
- Redirect with 2 in flight: branch_i=1, target 0x102 → both stale responses dropped; next v_o has pc_o=0x100 and that address's instruction.
- Branch in the same cycle as rvalid, and back-to-back branches to 0x200 then 0x300 → no stale instruction reaches v_o; first valid pc_o=0x300.
- With FETCH_PERF_EN: 5 pops and 2 redirects → perf_fetch_o=5, perf_redirect_o=2.
